// File: rtl/otp_ctrl_prog_seq.sv
// OTP programming sequencer: writes a snapshot of NumWords words to consecutive OTP addresses.
// Define OTP_PROG_SKIP_ZERO_EN to skip all-zero words instead of writing them.
module otp_ctrl_prog_seq #(
    parameter int unsigned          NumWords  = 10,
    parameter int unsigned          WordWidth = 16,
    parameter int unsigned          AddrWidth = 11,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          esc_i,
    input  logic                          req_i,
    input  logic [NumWords*WordWidth-1:0] data_i,
    output logic                          ack_o,
    output logic                          err_o,
    output logic [2:0]                    error_o,
    output logic                          fsm_err_o,
    output logic                          idle_o,
    output logic                          otp_req_o,
    output logic                          otp_cmd_o,
    output logic [AddrWidth-1:0]          otp_addr_o,
    output logic [WordWidth-1:0]          otp_wdata_o,
    input  logic                          otp_gnt_i,
    input  logic                          otp_rvalid_i,
    input  logic [2:0]                    otp_err_i
);

    localparam int unsigned     CntW        = $clog2(NumWords);
    localparam logic [CntW-1:0] LastCnt     = CntW'(NumWords - 1);
    localparam logic [2:0]      NoErr       = 3'd0;
    localparam logic [2:0]      FsmStateErr = 3'd7;

    // Pairwise Hamming distance of at least 4 between all encodings.
    typedef enum logic [7:0] {
        ResetSt     = 8'b0000_0000,
        IdleSt      = 8'b0000_1111,
        WriteSt     = 8'b1111_0000,
        WriteWaitSt = 8'b0011_1100,
        ErrorSt     = 8'b1100_0011
    } state_e;

    state_e                             state_q, state_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [CntW-1:0]                    cnt_n_q, cnt_n_d;
    logic [NumWords-1:0][WordWidth-1:0] words_q, words_d;
    logic [2:0]                         error_q, error_d;
    logic                               ack_q, ack_d;
    logic                               err_q, err_d;
    logic                               fsm_err_q, fsm_err_d;

    logic [CntW-1:0]      cnt_inc;
    logic                 cnt_mismatch;
    logic [WordWidth-1:0] cur_word;
    logic                 skip_zero;
    logic                 step;
    logic [2:0]           rsp_err;

    assign cnt_inc      = cnt_q + 1'b1;
    assign cnt_mismatch = (cnt_q != ~cnt_n_q);
    assign cur_word     = words_q[cnt_q];

`ifdef OTP_PROG_SKIP_ZERO_EN
    assign skip_zero = (state_q == WriteSt) && (cur_word == '0);
`else
    assign skip_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_n_d   = cnt_n_q;
        words_d   = words_q;
        error_d   = error_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        fsm_err_d = 1'b0;
        step      = 1'b0;
        rsp_err   = NoErr;

        case (state_q)
            ResetSt: begin
                if (en_i) state_d = IdleSt;
            end
            IdleSt: begin
                if (req_i) begin
                    words_d = data_i;
                    cnt_d   = '0;
                    cnt_n_d = '1;
                    state_d = WriteSt;
                end
            end
            WriteSt: begin
                if (skip_zero) step = 1'b1;
                else if (otp_gnt_i) state_d = WriteWaitSt;
            end
            WriteWaitSt: begin
                if (otp_rvalid_i) begin
                    step    = 1'b1;
                    rsp_err = otp_err_i;
                end
            end
            ErrorSt: begin
                if (error_q == NoErr) error_d = FsmStateErr;
            end
            default: begin
                state_d   = ErrorSt;
                fsm_err_d = 1'b1;
            end
        endcase

        // A skipped word and a write response share the same advance/complete path.
        if (step) begin
            if (error_q == NoErr) error_d = rsp_err;
            if (cnt_q != LastCnt) begin
                cnt_d   = cnt_inc;
                cnt_n_d = ~cnt_inc;
                state_d = WriteSt;
            end else begin
                ack_d = 1'b1;
                if (error_q != NoErr || rsp_err != NoErr) begin
                    err_d   = 1'b1;
                    state_d = ErrorSt;
                end else begin
                    state_d = IdleSt;
                end
            end
        end

        if (esc_i || cnt_mismatch) begin
            state_d   = ErrorSt;
            fsm_err_d = 1'b1;
            ack_d     = 1'b0;
            err_d     = 1'b0;
            if (error_q == NoErr) error_d = FsmStateErr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetSt;
            cnt_q     <= '0;
            cnt_n_q   <= '1;
            words_q   <= '0;
            error_q   <= NoErr;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            fsm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_n_q   <= cnt_n_d;
            words_q   <= words_d;
            error_q   <= error_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            fsm_err_q <= fsm_err_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign error_o     = error_q;
    assign fsm_err_o   = fsm_err_q;
    assign idle_o      = (state_q == IdleSt) || (state_q == ErrorSt);
    assign otp_req_o   = (state_q == WriteSt) && !skip_zero;
    assign otp_cmd_o   = otp_req_o;
    assign otp_addr_o  = otp_req_o ? BaseAddr + AddrWidth'(cnt_q) : '0;
    assign otp_wdata_o = otp_req_o ? cur_word : '0;

endmodule

// File: tb/tb_otp_ctrl_prog_seq.sv
// Scoreboard bench for otp_ctrl_prog_seq: directed requests push expected writes/acks,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_otp_ctrl_prog_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, esc, req;
    logic [63:0] data;
    logic        ack, err, fsm_err, idle;
    logic [2:0]  error_code;
    logic        otp_req, otp_cmd, otp_gnt, otp_rvalid;
    logic [10:0] otp_addr;
    logic [15:0] otp_wdata;
    logic [2:0]  otp_err;

    logic [10:0] block_addr = 11'h7FF;
    logic [2:0]  rsp_tbl [4];

    logic [26:0] wr_q [$];
    logic [3:0]  ack_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_seen = 0;

    always #5 clk = ~clk;

    // OTP macro model: grants immediately unless the address is blocked.
    assign otp_gnt = otp_req && (otp_addr != block_addr);

    otp_ctrl_prog_seq #(
        .NumWords (4),
        .WordWidth(16),
        .AddrWidth(11),
        .BaseAddr (11'h10)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .esc_i       (esc),
        .req_i       (req),
        .data_i      (data),
        .ack_o       (ack),
        .err_o       (err),
        .error_o     (error_code),
        .fsm_err_o   (fsm_err),
        .idle_o      (idle),
        .otp_req_o   (otp_req),
        .otp_cmd_o   (otp_cmd),
        .otp_addr_o  (otp_addr),
        .otp_wdata_o (otp_wdata),
        .otp_gnt_i   (otp_gnt),
        .otp_rvalid_i(otp_rvalid),
        .otp_err_i   (otp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [10:0] a, input logic [15:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic expect_ack(input logic e, input logic [2:0] c);
        ack_q.push_back({e, c});
    endtask

    task automatic issue(input logic [63:0] words);
        data = words;
        req  = 1'b1;
        tick();
        req  = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int start;
        start = ack_seen;
        for (int i = 0; i < 200 && ack_seen == start; i++) tick();
        check(name, 32'(ack_seen), 32'(start + 1));
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_rst_error"}, 32'(error_code), 32'h0);
        check({name, "_rst_idle"}, 32'(idle), 32'h0);
        check({name, "_rst_req"}, 32'(otp_req), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Response model: rvalid one cycle after the grant, code from rsp_tbl by word offset.
    initial begin
        logic [10:0] off;
        otp_rvalid = 1'b0;
        otp_err    = 3'd0;
        forever begin
            @(negedge clk);
            if (otp_req && otp_gnt) begin
                off = otp_addr - 11'h10;
                @(posedge clk);
                #1;
                otp_rvalid = 1'b1;
                otp_err    = rsp_tbl[off[1:0]];
                @(posedge clk);
                #1;
                otp_rvalid = 1'b0;
                otp_err    = 3'd0;
            end
        end
    end

    always @(negedge clk) begin
        logic [26:0] ew;
        logic [3:0]  ea;
        if (rst_n) begin
            if (otp_req && otp_gnt) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", otp_addr, otp_wdata);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(otp_addr), 32'(ew[26:16]));
                    check("wr_data", 32'(otp_wdata), 32'(ew[15:0]));
                    check("wr_cmd", 32'(otp_cmd), 32'h1);
                end
            end
            if (!otp_req) check("bus_quiet", {15'h0, otp_cmd, otp_wdata}, 32'h0);
            if (ack) begin
                ack_seen++;
                if (ack_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_unexpected: got ack err %0h code %0h, expected none", err, error_code);
                end else begin
                    ea = ack_q.pop_front();
                    check("ack_err", 32'(err), 32'(ea[3]));
                    check("ack_code", 32'(error_code), 32'(ea[2:0]));
                end
            end else if (err) begin
                check("err_without_ack", 32'(err), 32'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        esc   = 1'b0;
        req   = 1'b0;
        data  = '0;
        for (int i = 0; i < 4; i++) rsp_tbl[i] = 3'd0;
        repeat (3) tick();
        check("rst_idle", 32'(idle), 32'h0);
        check("rst_ack", {30'h0, ack, err}, 32'h0);
        check("rst_error", 32'(error_code), 32'h0);
        check("rst_fsm_err", 32'(fsm_err), 32'h0);
        check("rst_otp", {otp_req, otp_cmd, 3'h0, otp_addr, otp_wdata}, 32'h0);

        rst_n = 1'b1;
        repeat (2) tick();
        check("no_en_idle", 32'(idle), 32'h0);
        en = 1'b1;
        tick();
        check("en_idle", 32'(idle), 32'h1);

        // Basic four-word program
        expect_wr(11'h10, 16'h0001);
        expect_wr(11'h11, 16'h0002);
        expect_wr(11'h12, 16'h0003);
        expect_wr(11'h13, 16'h0004);
        expect_ack(1'b0, 3'd0);
        issue({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check("s1_busy_idle", 32'(idle), 32'h0);
        wait_ack("s1_ack_count");
        check("s1_idle", 32'(idle), 32'h1);

        // data_i changes after acceptance must not affect written data
        expect_wr(11'h10, 16'hA5A5);
        expect_wr(11'h11, 16'h5A5A);
        expect_wr(11'h12, 16'h1234);
        expect_wr(11'h13, 16'hFFFF);
        expect_ack(1'b0, 3'd0);
        issue({16'hFFFF, 16'h1234, 16'h5A5A, 16'hA5A5});
        data = 64'h0BAD_0BAD_0BAD_0BAD;
        wait_ack("s4_ack_count");

        // Error responses: first code sticks, all words still written, terminal error state
        rsp_tbl[1] = 3'd2;
        rsp_tbl[3] = 3'd3;
        expect_wr(11'h10, 16'h0011);
        expect_wr(11'h11, 16'h0022);
        expect_wr(11'h12, 16'h0033);
        expect_wr(11'h13, 16'h0044);
        expect_ack(1'b1, 3'd2);
        issue({16'h0044, 16'h0033, 16'h0022, 16'h0011});
        wait_ack("s2_ack_count");
        rsp_tbl[1] = 3'd0;
        rsp_tbl[3] = 3'd0;
        check("s2_error", 32'(error_code), 32'h2);
        check("s2_idle", 32'(idle), 32'h1);
        issue({16'h0001, 16'h0001, 16'h0001, 16'h0001});
        repeat (8) tick();
        check("s2_req_ignored", 32'(otp_req), 32'h0);
        check("s2_error_hold", 32'(error_code), 32'h2);
        do_reset("s2");

        // Escalation while word 2 waits for its grant
        block_addr = 11'h12;
        expect_wr(11'h10, 16'h0101);
        expect_wr(11'h11, 16'h0202);
        issue({16'h0404, 16'h0303, 16'h0202, 16'h0101});
        for (int i = 0; i < 50 && !(otp_req && otp_addr == 11'h12); i++) tick();
        check("s3_wait_addr", 32'(otp_addr), 32'h12);
        esc = 1'b1;
        tick();
        esc = 1'b0;
        check("s3_fsm_err", 32'(fsm_err), 32'h1);
        check("s3_error", 32'(error_code), 32'h7);
        check("s3_req", 32'(otp_req), 32'h0);
        check("s3_idle", 32'(idle), 32'h1);
        tick();
        check("s3_fsm_err_pulse", 32'(fsm_err), 32'h0);
        block_addr = 11'h7FF;
        do_reset("s3");

        // Reset during WriteWaitSt abandons the sequence
        expect_wr(11'h10, 16'h1111);
        expect_wr(11'h11, 16'h2222);
        issue({16'h4444, 16'h3333, 16'h2222, 16'h1111});
        for (int i = 0; i < 50 && !(otp_req && otp_addr == 11'h11); i++) tick();
        check("s5_wait_addr", 32'(otp_addr), 32'h11);
        tick();
        rst_n = 1'b0;
        #1;
        check("s5_ack", 32'(ack), 32'h0);
        check("s5_idle", 32'(idle), 32'h0);
        check("s5_error", 32'(error_code), 32'h0);
        check("s5_req", 32'(otp_req), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("s5_back_idle", 32'(idle), 32'h1);
        expect_wr(11'h10, 16'h00AA);
        expect_wr(11'h11, 16'h00BB);
        expect_wr(11'h12, 16'h00CC);
        expect_wr(11'h13, 16'h00DD);
        expect_ack(1'b0, 3'd0);
        issue({16'h00DD, 16'h00CC, 16'h00BB, 16'h00AA});
        wait_ack("s5_ack_count");

        // Zero words: skipped with the macro, written without it
        expect_wr(11'h10, 16'h0005);
`ifndef OTP_PROG_SKIP_ZERO_EN
        expect_wr(11'h11, 16'h0000);
        expect_wr(11'h12, 16'h0000);
`endif
        expect_wr(11'h13, 16'h0007);
        expect_ack(1'b0, 3'd0);
        issue({16'h0007, 16'h0000, 16'h0000, 16'h0005});
        wait_ack("s6_ack_count");
        check("s6_idle", 32'(idle), 32'h1);

        repeat (3) tick();
        check("wr_queue_drained", 32'(wr_q.size()), 32'h0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/otp_ctrl_prog_seq.md
OTP_CTRL_PROG_SEQ -- requirements
Module: otp_ctrl_prog_seq

Interface
REQ-001 SHALL have parameter NumWords, default 10, number of OTP words programmed per request (>=2).
REQ-002 SHALL have parameter WordWidth, default 16, native OTP word width in bits.
REQ-003 SHALL have parameter AddrWidth, default 11, OTP word-address width.
REQ-004 SHALL have parameter BaseAddr, default 0, first OTP word address (AddrWidth bits).
REQ-005 SHALL have ports, in order:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  sequencer enable.
- esc_i  in  1  escalation.
- req_i  in  1  program request.
- data_i  in  NumWords*WordWidth  words to program; word k at bits [k*WordWidth +: WordWidth].
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle failure pulse, concurrent with ack_o.
- error_o  out  3  latched error code: 0 None, 1 Macro, 2 EccCorr, 3 EccUncorr, 4 WriteBlank, 7 FsmState.
- fsm_err_o  out  1  pulse on escalation or invalid state.
- idle_o  out  1  low while programming or in reset state.
- otp_req_o  out  1  OTP request.
- otp_cmd_o  out  1  0 = read, 1 = write.
- otp_addr_o  out  AddrWidth  OTP word address.
- otp_wdata_o  out  WordWidth  write data.
- otp_gnt_i  in  1  OTP grant.
- otp_rvalid_i  in  1  OTP response valid.
- otp_err_i  in  3  OTP response code, same encoding as error_o.

Function
REQ-006 SHALL implement states ResetSt, IdleSt, WriteSt, WriteWaitSt and ErrorSt with sparse encoding, minimum Hamming distance 4.
REQ-007 SHALL move from ResetSt to IdleSt on the first cycle en_i=1.
REQ-008 SHALL, in IdleSt with req_i=1, snapshot data_i into an internal register, clear the word counter and go to WriteSt; data_i changes afterwards have no effect.
REQ-009 SHALL ignore req_i in every state other than IdleSt.
REQ-010 SHALL, in WriteSt, drive otp_req_o=1, otp_cmd_o=1, otp_addr_o=BaseAddr+cnt (modulo 2^AddrWidth) and otp_wdata_o=snapshot word cnt.
REQ-011 SHALL hold WriteSt until otp_gnt_i=1, then go to WriteWaitSt.
REQ-012 SHALL drive otp_wdata_o=0 and otp_cmd_o=0 whenever otp_req_o=0.
REQ-013 SHALL, in WriteWaitSt on otp_rvalid_i=1 with nonzero otp_err_i, latch that code only if error_o is 0 (first error sticky), and still program the remaining words.
REQ-014 SHALL, in WriteWaitSt on otp_rvalid_i=1:
- cnt < NumWords-1: increment cnt and return to WriteSt.
- otherwise: pulse ack_o; if the aggregated error, including the current response, is nonzero, also pulse err_o and go to ErrorSt; else return to IdleSt.
REQ-015 SHALL ignore otp_rvalid_i and otp_gnt_i outside WriteWaitSt and WriteSt respectively.
REQ-016 SHALL use a redundant word counter; a counter mismatch is treated as escalation.
REQ-017 SHALL, on esc_i=1 or counter mismatch in any state, go to ErrorSt next cycle and pulse fsm_err_o; error_o becomes 7 if it was 0.
REQ-018 SHALL, on an invalid state encoding, go to ErrorSt and pulse fsm_err_o.
REQ-019 SHALL treat ErrorSt as terminal until reset, with no OTP requests, no ack_o, and error_o forced to 7 if it was 0.
REQ-020 SHALL drive idle_o=1 only in IdleSt and ErrorSt.

Reset
REQ-021 SHALL, while rst_ni=0, enter ResetSt and clear cnt, the snapshot and error_o; all outputs are 0 except idle_o=0.
REQ-022 SHALL, on reset mid-transfer, abandon the sequence with no ack_o and deassert otp_req_o immediately.

Configuration
REQ-023 SHALL provide macro OTP_PROG_SKIP_ZERO_EN, which enables zero-word skipping.
- Defined: in WriteSt, an all-zero snapshot word issues no OTP request and is treated as a NoError response in the same cycle (counter advance, or completion per REQ-014, without entering WriteWaitSt).
- Undefined: every word is written, including zero words.

Verification
REQ-024 SHALL cover these directed scenarios (NumWords=4, BaseAddr=0x10, immediate gnt, rvalid one cycle after gnt):
- req with words 1,2,3,4, all responses 0 -> four writes at addresses 0x10..0x13, ack_o=1, err_o=0, back in IdleSt.
- Word 1 response 2, word 3 response 3 -> all four writes issued, ack_o=1, err_o=1, error_o=2, ErrorSt.
- esc_i=1 while waiting for gnt on word 2 -> ErrorSt next cycle, fsm_err_o=1, error_o=7, otp_req_o=0.
- data_i changed after acceptance -> otp_wdata_o shows the snapshot values.
- rst_ni=0 during WriteWaitSt -> no ack_o, idle_o=0, error_o=0; next req completes normally.
- With OTP_PROG_SKIP_ZERO_EN and words 5,0,0,7 -> only addresses 0x10 and 0x13 requested, ack_o=1. Without the macro -> four requests.
